// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter that shares one memory port between the IFU (read-only)
// and the LSU (load/store), with round-robin tie-break and a WAIT-phase timeout.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_rsp_valid,
    output logic [DATA_W-1:0]     ifu_rdata,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_rsp_valid,
    output logic [DATA_W-1:0]     lsu_rdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  busy,
    output logic                  timeout_err
);

    localparam int                CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [DATA_W-1:0] ABORT_DATA  = DATA_W'(32'hDEAD_BEEF);
    localparam logic              OWNER_IFU   = 1'b0;
    localparam logic              OWNER_LSU   = 1'b1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                state_reg;
    logic                  owner_reg;
    logic                  last_owner_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic                  wen_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [DATA_W/8-1:0]   wmask_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [DATA_W-1:0]     ifu_rdata_reg;
    logic [DATA_W-1:0]     lsu_rdata_reg;
    logic                  ifu_rsp_reg;
    logic                  lsu_rsp_reg;
    logic                  timeout_reg;
    logic                  mem_req_reg;
    logic                  busy_reg;

    logic                  grant_ifu;
    logic                  grant_lsu;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  abort_now;
    logic [DATA_W-1:0]     rsp_data;

    // Ready is gated by rst so nothing can be accepted while reset is held.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (rst && state_reg == IDLE) begin
            grant_ifu = ifu_req_valid && (!lsu_req_valid || last_owner_reg == OWNER_LSU);
            grant_lsu = lsu_req_valid && (!ifu_req_valid || last_owner_reg == OWNER_IFU);
        end
    end

    assign cnt_inc   = cnt_reg + CNT_W'(1);
    assign abort_now = !mem_rsp_valid && (cnt_inc == TIMEOUT_CNT);

    // A real response wins over an abort landing in the same cycle; stores return 0.
    always_comb begin
        rsp_data = ABORT_DATA;
        if (mem_rsp_valid) begin
            rsp_data = wen_reg ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            owner_reg      <= OWNER_IFU;
            last_owner_reg <= OWNER_LSU;
            addr_reg       <= '0;
            wen_reg        <= 1'b0;
            wdata_reg      <= '0;
            wmask_reg      <= '0;
            cnt_reg        <= '0;
            ifu_rdata_reg  <= '0;
            lsu_rdata_reg  <= '0;
            ifu_rsp_reg    <= 1'b0;
            lsu_rsp_reg    <= 1'b0;
            timeout_reg    <= 1'b0;
            mem_req_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            ifu_rsp_reg <= 1'b0;
            lsu_rsp_reg <= 1'b0;
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_ifu) begin
                        owner_reg   <= OWNER_IFU;
                        addr_reg    <= ifu_addr;
                        wen_reg     <= 1'b0;
                        wdata_reg   <= '0;
                        wmask_reg   <= '0;
                        mem_req_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= REQ;
                    end else if (grant_lsu) begin
                        owner_reg   <= OWNER_LSU;
                        addr_reg    <= lsu_addr;
                        wen_reg     <= lsu_wen;
                        wdata_reg   <= lsu_wdata;
                        wmask_reg   <= lsu_wmask;
                        mem_req_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_reg <= 1'b0;
                        cnt_reg     <= '0;
                        state_reg   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid || abort_now) begin
                        if (owner_reg == OWNER_LSU) begin
                            lsu_rdata_reg <= rsp_data;
                            lsu_rsp_reg   <= 1'b1;
                        end else begin
                            ifu_rdata_reg <= rsp_data;
                            ifu_rsp_reg   <= 1'b1;
                        end
                        timeout_reg <= abort_now;
                        state_reg   <= RESP;
                    end
                    // Saturates at TIMEOUT because the abort leaves WAIT on that step.
                    if (!mem_rsp_valid) begin
                        cnt_reg <= cnt_inc;
                    end
                end
                RESP: begin
                    last_owner_reg <= owner_reg;
                    busy_reg       <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;
    assign ifu_rsp_valid = ifu_rsp_reg;
    assign ifu_rdata     = ifu_rdata_reg;
    assign lsu_rsp_valid = lsu_rsp_reg;
    assign lsu_rdata     = lsu_rdata_reg;
    assign mem_req_valid = mem_req_reg;
    assign mem_addr      = addr_reg;
    assign mem_wen       = wen_reg;
    assign mem_wdata     = wdata_reg;
    assign mem_wmask     = wmask_reg;
    assign busy          = busy_reg;
    assign timeout_err   = timeout_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        lsu_req_valid = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid;
    logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
    logic        mem_req_valid, mem_wen, busy, timeout_err;
    logic [3:0]  mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- reference model (transaction view) ----------------
    bit          m_busy = 1'b0;     // a transaction is owned by the arbiter
    bit          m_issued = 1'b0;   // memory has taken the request
    bit          m_done = 1'b0;     // result is being presented this cycle
    bit          m_owner = 1'b0;    // 1 = LSU
    bit          m_last = 1'b1;     // 1 = LSU served last
    int          m_waited = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic        m_wen = 1'b0;
    logic [3:0]  m_wmask = '0;
    logic [31:0] m_ifu_rdata = '0, m_lsu_rdata = '0;
    bit          m_ifu_pulse = 1'b0, m_lsu_pulse = 1'b0, m_terr = 1'b0;

    function automatic logic [31:0] result_of(input bit got_rsp, input bit was_store,
                                              input logic [31:0] d);
        if (!got_rsp) return 32'hDEAD_BEEF;
        return was_store ? 32'h0 : d;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0; m_issued <= 1'b0; m_done <= 1'b0; m_owner <= 1'b0;
            m_last <= 1'b1; m_waited <= 0;
            m_addr <= '0; m_wdata <= '0; m_wen <= 1'b0; m_wmask <= '0;
            m_ifu_rdata <= '0; m_lsu_rdata <= '0;
            m_ifu_pulse <= 1'b0; m_lsu_pulse <= 1'b0; m_terr <= 1'b0;
        end else begin
            m_ifu_pulse <= 1'b0;
            m_lsu_pulse <= 1'b0;
            m_terr      <= 1'b0;
            if (!m_busy) begin
                if (ifu_req_valid && (!lsu_req_valid || m_last)) begin
                    m_busy <= 1'b1; m_issued <= 1'b0; m_owner <= 1'b0;
                    m_addr <= ifu_addr; m_wen <= 1'b0; m_wdata <= '0; m_wmask <= '0;
                end else if (lsu_req_valid) begin
                    m_busy <= 1'b1; m_issued <= 1'b0; m_owner <= 1'b1;
                    m_addr <= lsu_addr; m_wen <= lsu_wen; m_wdata <= lsu_wdata; m_wmask <= lsu_wmask;
                end
            end else if (m_done) begin
                m_busy <= 1'b0; m_done <= 1'b0; m_last <= m_owner;
            end else if (!m_issued) begin
                if (mem_req_ready) begin
                    m_issued <= 1'b1; m_waited <= 0;
                end
            end else if (mem_rsp_valid || (m_waited + 1 == TO)) begin
                m_done <= 1'b1;
                m_terr <= !mem_rsp_valid;
                if (m_owner) begin
                    m_lsu_rdata <= result_of(mem_rsp_valid, m_wen, mem_rdata);
                    m_lsu_pulse <= 1'b1;
                end else begin
                    m_ifu_rdata <= result_of(mem_rsp_valid, m_wen, mem_rdata);
                    m_ifu_pulse <= 1'b1;
                end
            end else begin
                m_waited <= m_waited + 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin : compare
        bit exp_ifu_rdy, exp_lsu_rdy;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                exp_ifu_rdy = rst && !m_busy && ifu_req_valid && (!lsu_req_valid || m_last);
                exp_lsu_rdy = rst && !m_busy && lsu_req_valid && (!ifu_req_valid || !m_last);
                check("m_ifu_req_ready", ifu_req_ready, exp_ifu_rdy);
                check("m_lsu_req_ready", lsu_req_ready, exp_lsu_rdy);
                check("m_ifu_rsp_valid", ifu_rsp_valid, m_ifu_pulse);
                check("m_ifu_rdata", ifu_rdata, m_ifu_rdata);
                check("m_lsu_rsp_valid", lsu_rsp_valid, m_lsu_pulse);
                check("m_lsu_rdata", lsu_rdata, m_lsu_rdata);
                check("m_mem_req_valid", mem_req_valid, m_busy && !m_issued);
                check("m_mem_addr", mem_addr, m_addr);
                check("m_mem_wen", mem_wen, m_wen);
                check("m_mem_wdata", mem_wdata, m_wdata);
                check("m_mem_wmask", mem_wmask, m_wmask);
                check("m_busy", busy, m_busy);
                check("m_timeout_err", timeout_err, m_terr);
            end
        end
    end

    // ---------------- memory responder ----------------
    int          cfg_rdy = 0;       // REQ cycles before mem_req_ready
    int          cfg_rsp = 0;       // WAIT cycles before mem_rsp_valid (-1: never)
    logic [31:0] cfg_rdata = '0;
    bit          stray_rsp = 1'b0;

    initial begin : responder
        int req_cnt, wait_cnt;
        bit in_wait;
        req_cnt = 0; wait_cnt = 0; in_wait = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (!rst) begin
                in_wait = 1'b0; req_cnt = 0;
            end else if (mem_req_valid) begin
                in_wait = 1'b0;
                if (req_cnt >= cfg_rdy) begin
                    mem_req_ready = 1'b1; in_wait = 1'b1; wait_cnt = 0; req_cnt = 0;
                end else begin
                    req_cnt++;
                end
            end else if (in_wait) begin
                if (wait_cnt == cfg_rsp) begin
                    mem_rsp_valid = 1'b1; mem_rdata = cfg_rdata; in_wait = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end
            if (stray_rsp) begin
                mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_grant(input bit lsu);
        int n;
        n = 0;
        @(negedge clk);
        while (!(lsu ? lsu_req_ready : ifu_req_ready) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check(lsu ? "grant_lsu_timeout" : "grant_ifu_timeout",
                           lsu ? lsu_req_ready : ifu_req_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("idle_timeout", busy, 0);
        @(posedge clk);
        #1;
    endtask

    bit grants[4];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin : stimulus
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;

        // Reset holds ready low even with a request pending.
        ifu_req_valid = 1'b1; ifu_addr = 32'h0000_1234;
        @(negedge clk);
        check("rst_ifu_ready", ifu_req_ready, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;

        // 1: single IFU read, minimum latency.
        cfg_rdy = 0; cfg_rsp = 0; cfg_rdata = 32'h0010_0093;
        ifu_addr = 32'h8000_0000; ifu_req_valid = 1'b1;
        wait_grant(1'b0);
        ifu_req_valid = 1'b0;
        @(negedge clk);
        check("t1_mem_req_valid", mem_req_valid, 1);
        check("t1_mem_addr", mem_addr, 32'h8000_0000);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_early_rsp", ifu_rsp_valid, 0);
        @(negedge clk);
        check("t1_ifu_rsp_valid", ifu_rsp_valid, 1);
        check("t1_ifu_rdata", ifu_rdata, 32'h0010_0093);
        check("t1_lsu_rsp_valid", lsu_rsp_valid, 0);
        @(negedge clk);
        check("t1_rsp_one_cycle", ifu_rsp_valid, 0);
        check("t1_rdata_held", ifu_rdata, 32'h0010_0093);
        wait_idle();

        // 2: LSU store, rdata returned as 0.
        cfg_rdy = 0; cfg_rsp = 0; cfg_rdata = 32'h1234_5678;
        lsu_addr = 32'h8000_1000; lsu_wen = 1'b1; lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 4'b0011;
        lsu_req_valid = 1'b1;
        wait_grant(1'b1);
        lsu_req_valid = 1'b0;
        @(negedge clk);
        check("t2_mem_addr", mem_addr, 32'h8000_1000);
        check("t2_mem_wen", mem_wen, 1);
        check("t2_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        check("t2_mem_wmask", mem_wmask, 4'b0011);
        @(negedge clk);
        @(negedge clk);
        check("t2_lsu_rsp_valid", lsu_rsp_valid, 1);
        check("t2_lsu_rdata", lsu_rdata, 0);
        check("t2_ifu_rsp_valid", ifu_rsp_valid, 0);
        wait_idle();

        // 3: both requesters held valid, round-robin grant order.
        cfg_rdy = 0; cfg_rsp = 0; cfg_rdata = 32'h0BAD_0001;
        ifu_addr = 32'h8000_0100; lsu_addr = 32'h8000_2000;
        lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            @(negedge clk);
            while (!ifu_req_ready && !lsu_req_ready && n < 50) begin
                n++;
                @(negedge clk);
            end
            if (n >= 50) check("t3_grant_timeout", ifu_req_ready | lsu_req_ready, 1);
            grants[k] = lsu_req_ready;
            @(posedge clk); #1;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        check("t3_grant0_ifu", grants[0], 0);
        check("t3_grant1_lsu", grants[1], 1);
        check("t3_grant2_ifu", grants[2], 0);
        check("t3_grant3_lsu", grants[3], 1);
        wait_idle();

        // 4: memory stalls request 5 cycles, responds in the first WAIT cycle.
        cfg_rdy = 5; cfg_rsp = 0; cfg_rdata = 32'h7777_7777;
        lsu_addr = 32'h8000_3000; lsu_wen = 1'b1; lsu_wdata = 32'h1111_2222; lsu_wmask = 4'hF;
        lsu_req_valid = 1'b1;
        wait_grant(1'b1);
        lsu_req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("t4_mem_addr_stable", mem_addr, 32'h8000_3000);
            check("t4_mem_req_valid", mem_req_valid, 1);
            check("t4_busy_req", busy, 1);
        end
        @(negedge clk);
        check("t4_req_dropped", mem_req_valid, 0);
        check("t4_busy_wait", busy, 1);
        check("t4_no_early_rsp", lsu_rsp_valid, 0);
        @(negedge clk);
        check("t4_lsu_rsp_valid", lsu_rsp_valid, 1);
        check("t4_busy_resp", busy, 1);
        check("t4_lsu_rdata", lsu_rdata, 0);
        @(negedge clk);
        check("t4_single_pulse", lsu_rsp_valid, 0);
        check("t4_busy_idle", busy, 0);
        wait_idle();

        // 4b: response on the last allowed WAIT cycle still wins over the abort.
        cfg_rdy = 0; cfg_rsp = TO - 1; cfg_rdata = 32'h0000_0513;
        ifu_addr = 32'h8000_0004; ifu_req_valid = 1'b1;
        wait_grant(1'b0);
        ifu_req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("t4b_no_rsp_yet", ifu_rsp_valid, 0);
        @(negedge clk);
        check("t4b_ifu_rsp_valid", ifu_rsp_valid, 1);
        check("t4b_ifu_rdata", ifu_rdata, 32'h0000_0513);
        check("t4b_no_timeout", timeout_err, 0);
        wait_idle();

        // 5: no memory response, abort after TIMEOUT WAIT cycles.
        cfg_rdy = 0; cfg_rsp = -1; cfg_rdata = 32'h0;
        lsu_addr = 32'h8000_0008; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        lsu_req_valid = 1'b1;
        wait_grant(1'b1);
        lsu_req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_no_early_timeout", timeout_err, 0);
        check("t5_busy_wait", busy, 1);
        @(negedge clk);
        check("t5_timeout_err", timeout_err, 1);
        check("t5_lsu_rsp_valid", lsu_rsp_valid, 1);
        check("t5_lsu_rdata", lsu_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t5_timeout_pulse", timeout_err, 0);
        check("t5_idle", busy, 0);
        wait_idle();

        // 6: reset asserted during WAIT, then a stray memory response.
        cfg_rdy = 0; cfg_rsp = -1;
        ifu_addr = 32'h8000_000C; ifu_req_valid = 1'b1;
        wait_grant(1'b0);
        ifu_req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_busy_before", busy, 1);
        @(posedge clk); #1;
        rst = 1'b0; ifu_req_valid = 1'b1;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_mem_req_valid", mem_req_valid, 0);
        check("t6_rst_mem_addr", mem_addr, 0);
        check("t6_rst_ifu_rdata", ifu_rdata, 0);
        check("t6_rst_lsu_rdata", lsu_rdata, 0);
        check("t6_rst_ifu_ready", ifu_req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        ifu_req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        stray_rsp = 1'b1;
        @(posedge clk); #1;
        stray_rsp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_stray_busy", busy, 0);
            check("t6_stray_ifu_rsp", ifu_rsp_valid, 0);
            check("t6_stray_lsu_rsp", lsu_rsp_valid, 0);
        end

        // After reset the first tie goes to the IFU again.
        @(posedge clk); #1;
        cfg_rdy = 0; cfg_rsp = 0; cfg_rdata = 32'h0000_0001;
        ifu_addr = 32'h8000_0010; lsu_addr = 32'h8000_0020;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        @(negedge clk);
        check("t7_tie_ifu_ready", ifu_req_ready, 1);
        check("t7_tie_lsu_ready", lsu_req_ready, 0);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
